ow_temp_seq: RTL and testbench

OW_TEMP_SEQ -- requirements
Module: ow_temp_seq

---
 rtl/ow_pkg.sv | 60 ++++++
 rtl/ow_crc8.sv | 24 ++
 rtl/ow_temp_seq.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ow_temp_seq.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ow_pkg.sv
// Shared types and constants for the 1-Wire temperature sequencer.
// Holds the state/sub-phase enums, ROM/function codes and CRC-8 step.
package ow_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST1,
    S_CONV_CMD,
    S_WAIT_CONV,
    S_RST2,
    S_READ_CMD,
    S_READ,
    S_READ_CRC,
    S_CHECK,
    S_DONE
  } ow_state_e;

  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_ACK,
    PH_FIN
  } ow_phase_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_RESET,
    OP_WRITE,
    OP_READ
  } ow_op_e;

  typedef struct packed {
    ow_op_e      op;
    logic [63:0] data;
    logic [5:0]  sb;
    logic [5:0]  eb;
  } ow_cmd_t;

  localparam logic [7:0] OW_SKIP_ROM  = 8'hCC;
  localparam logic [7:0] OW_CONVERT_T = 8'h44;
  localparam logic [7:0] OW_READ_SP   = 8'hBE;
  localparam logic [7:0] OW_CRC_POLY  = 8'h8C;

  // Skip ROM goes out first (bits 7:0), function code second.
  function automatic logic [63:0] ow_cmd_word(
    input logic [7:0] fn
  );
    return {48'd0, fn, OW_SKIP_ROM};
  endfunction

  // One LSB-first step of the reflected Dallas CRC-8.
  function automatic logic [7:0] ow_crc8_step(
    input logic [7:0] crc,
    input logic       b
  );
    logic fb;
    fb = crc[0] ^ b;
    return (crc >> 1) ^ (fb ? OW_CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ow_crc8.sv
// Serial Dallas CRC-8, one bit per clock, LSB first.
// Ports: clk, rst_n, clear, bit_valid, bit_in -> crc[7:0].
module ow_crc8
  import ow_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= 8'h00;
    end else if (bit_valid) begin
      crc <= ow_crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/ow_temp_seq.sv
// DS18B20-style conversion/read sequencer driving a 1-Wire engine.
// Ports: clk, rst_n, start; engine ow_reset/ow_write/ow_read,
// ow_in, ow_start_bit, ow_end_bit, ow_busy, ow_presence, ow_out;
// user busy, done, temp, err_nopres, err_crc.
// Macro OW_TEMP_CRC_EN: read full scratchpad + CRC byte and check.
module ow_temp_seq
  import ow_pkg::*;
#(
  parameter int CONV_CYCLES = 18000000
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        ow_reset,
  output logic        ow_write,
  output logic        ow_read,
  output logic [63:0] ow_in,
  output logic [5:0]  ow_start_bit,
  output logic [5:0]  ow_end_bit,
  input  logic        ow_busy,
  input  logic        ow_presence,
  input  logic [63:0] ow_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] temp,
  output logic        err_nopres,
  output logic        err_crc
);

  localparam logic [24:0] CONV_LAST =
    25'(CONV_CYCLES - 1);

  ow_state_e   state, state_d;
  ow_phase_e   phase, phase_d;
  logic [24:0] cnt, cnt_d;
  logic        ow_reset_d, ow_write_d, ow_read_d;
  logic [63:0] ow_in_d;
  logic [5:0]  sb_d, eb_d;
  logic        busy_d, done_d;
  logic [15:0] temp_d;
  logic        err_nopres_d;
  ow_cmd_t     cmd;
  logic        is_cmd;

`ifdef OW_TEMP_CRC_EN
  localparam logic [5:0] READ_EB = 6'd63;

  // Scratchpad bytes 0-7 plus CRC byte, shifted out LSB first.
  logic [71:0] sp, sp_d;
  logic        err_crc_d;
  logic [7:0]  crc;
  logic        crc_clear, crc_valid;

  assign crc_clear = (state == S_READ_CRC);
  assign crc_valid = (state == S_CHECK);

  ow_crc8 u_crc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (crc_clear),
    .bit_valid (crc_valid),
    .bit_in    (sp[0]),
    .crc       (crc)
  );
`else
  localparam logic [5:0] READ_EB = 6'd15;

  logic unused_ow_out;
  assign unused_ow_out = ^ow_out[63:16];
  assign err_crc       = 1'b0;
`endif

  always_comb begin
    cmd    = '{op: OP_NONE, data: '0,
               sb: '0, eb: '0};
    is_cmd = 1'b1;
    unique case (state)
      S_RST1, S_RST2: begin
        cmd.op = OP_RESET;
      end
      S_CONV_CMD: begin
        cmd.op   = OP_WRITE;
        cmd.data = ow_cmd_word(OW_CONVERT_T);
        cmd.eb   = 6'd15;
      end
      S_READ_CMD: begin
        cmd.op   = OP_WRITE;
        cmd.data = ow_cmd_word(OW_READ_SP);
        cmd.eb   = 6'd15;
      end
      S_READ: begin
        cmd.op = OP_READ;
        cmd.eb = READ_EB;
      end
      S_READ_CRC: begin
        cmd.op = OP_READ;
        cmd.eb = 6'd7;
      end
      default: is_cmd = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state;
    phase_d      = phase;
    cnt_d        = cnt;
    ow_reset_d   = 1'b0;
    ow_write_d   = 1'b0;
    ow_read_d    = 1'b0;
    ow_in_d      = ow_in;
    sb_d         = ow_start_bit;
    eb_d         = ow_end_bit;
    busy_d       = busy;
    done_d       = 1'b0;
    temp_d       = temp;
    err_nopres_d = err_nopres;
`ifdef OW_TEMP_CRC_EN
    sp_d         = sp;
    err_crc_d    = err_crc;
`endif

    unique case (state)
      S_IDLE: begin
        if (start) begin
          busy_d       = 1'b1;
          err_nopres_d = 1'b0;
`ifdef OW_TEMP_CRC_EN
          err_crc_d    = 1'b0;
`endif
          state_d      = S_RST1;
          phase_d      = PH_ISSUE;
        end
      end
      S_WAIT_CONV: begin
        if (cnt == CONV_LAST) begin
          cnt_d   = '0;
          state_d = S_RST2;
          phase_d = PH_ISSUE;
        end else begin
          cnt_d = cnt + 25'd1;
        end
      end
`ifdef OW_TEMP_CRC_EN
      S_CHECK: begin
        sp_d = sp >> 1;
        if (cnt == 25'd71) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt + 25'd1;
        end
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef OW_TEMP_CRC_EN
        err_crc_d = |crc;
`endif
      end
      default: begin
        if (is_cmd) begin
          unique case (phase)
            PH_ISSUE: begin
              // Never hand the engine a command it is still busy with.
              if (!ow_busy) begin
                unique case (1'b1)
                  cmd.op == OP_RESET: ow_reset_d = 1'b1;
                  cmd.op == OP_WRITE: ow_write_d = 1'b1;
                  cmd.op == OP_READ:  ow_read_d  = 1'b1;
                  default: ;
                endcase
                ow_in_d = cmd.data;
                sb_d    = cmd.sb;
                eb_d    = cmd.eb;
                phase_d = PH_ACK;
              end
            end
            PH_ACK: begin
              if (ow_busy) phase_d = PH_FIN;
            end
            PH_FIN: begin
              if (!ow_busy) begin
                phase_d = PH_ISSUE;
                unique case (state)
                  S_RST1, S_RST2: begin
                    if (!ow_presence) begin
                      err_nopres_d = 1'b1;
                      state_d      = S_DONE;
                    end else if (state == S_RST1) begin
                      state_d = S_CONV_CMD;
                    end else begin
                      state_d = S_READ_CMD;
                    end
                  end
                  S_CONV_CMD: begin
                    cnt_d   = '0;
                    state_d = S_WAIT_CONV;
                  end
                  S_READ_CMD: state_d = S_READ;
                  S_READ: begin
                    temp_d = ow_out[15:0];
`ifdef OW_TEMP_CRC_EN
                    sp_d[63:0] = ow_out;
                    state_d    = S_READ_CRC;
`else
                    state_d    = S_DONE;
`endif
                  end
`ifdef OW_TEMP_CRC_EN
                  S_READ_CRC: begin
                    sp_d[71:64] = ow_out[7:0];
                    cnt_d       = '0;
                    state_d     = S_CHECK;
                  end
`endif
                  default: state_d = S_IDLE;
                endcase
              end
            end
            default: phase_d = PH_ISSUE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      phase        <= PH_ISSUE;
      cnt          <= '0;
      ow_reset     <= 1'b0;
      ow_write     <= 1'b0;
      ow_read      <= 1'b0;
      ow_in        <= '0;
      ow_start_bit <= '0;
      ow_end_bit   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      temp         <= '0;
      err_nopres   <= 1'b0;
`ifdef OW_TEMP_CRC_EN
      sp           <= '0;
      err_crc      <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      phase        <= phase_d;
      cnt          <= cnt_d;
      ow_reset     <= ow_reset_d;
      ow_write     <= ow_write_d;
      ow_read      <= ow_read_d;
      ow_in        <= ow_in_d;
      ow_start_bit <= sb_d;
      ow_end_bit   <= eb_d;
      busy         <= busy_d;
      done         <= done_d;
      temp         <= temp_d;
      err_nopres   <= err_nopres_d;
`ifdef OW_TEMP_CRC_EN
      sp           <= sp_d;
      err_crc      <= err_crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_ow_temp_seq.sv
// Directed bench for ow_temp_seq with a behavioural 1-Wire engine.
// Engine goes busy the cycle after a strobe and stays busy 4 cycles.
module tb_ow_temp_seq;

  localparam int CONV = 100;

`ifdef OW_TEMP_CRC_EN
  localparam int       EXP_RD = 2;
  localparam bit [5:0] EXP_EB = 6'd63;
`else
  localparam int       EXP_RD = 1;
  localparam bit [5:0] EXP_EB = 6'd15;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ow_reset, ow_write, ow_read;
  logic [63:0] ow_in;
  logic [5:0]  ow_start_bit, ow_end_bit;
  logic        ow_busy, ow_presence;
  logic [63:0] ow_out;
  logic        busy, done;
  logic [15:0] temp;
  logic        err_nopres, err_crc;

  always #5 clk = ~clk;

  ow_temp_seq #(.CONV_CYCLES(CONV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ow_reset     (ow_reset),
    .ow_write     (ow_write),
    .ow_read      (ow_read),
    .ow_in        (ow_in),
    .ow_start_bit (ow_start_bit),
    .ow_end_bit   (ow_end_bit),
    .ow_busy      (ow_busy),
    .ow_presence  (ow_presence),
    .ow_out       (ow_out),
    .busy         (busy),
    .done         (done),
    .temp         (temp),
    .err_nopres   (err_nopres),
    .err_crc      (err_crc)
  );

  logic        eng_busy = 1'b0;
  logic        ext_busy = 1'b0;
  int          eng_timer = 0;
  int          rd_ptr = 0;
  logic [71:0] sp = '0;
  logic        pres_cfg = 1'b1;
  logic [63:0] out_next = '0;

  assign ow_busy = eng_busy | ext_busy;

  int          cyc = 0;
  int          n_rst, n_wr, n_rd, n_done, n_viol;
  int          last_fall, gap;
  logic [63:0] wr_in [4];
  logic [5:0]  wr_sb [4];
  logic [5:0]  wr_eb [4];
  logic [5:0]  rd_eb [4];

  int total = 0;
  int bad   = 0;

  initial begin
    ow_presence = 1'b0;
    ow_out      = '0;
  end

  always @(posedge clk) begin
    int          w;
    logic [71:0] sh;
    logic [63:0] mask;
    cyc++;
    if (done) n_done++;
    if (ow_reset | ow_write | ow_read) begin
      if (int'(ow_reset) + int'(ow_write) + int'(ow_read) != 1 || ow_busy)
        n_viol++;
      if (ow_reset) begin
        if (n_rst == 1) gap = cyc - last_fall;
        n_rst++;
        rd_ptr = 0;
      end
      if (ow_write) begin
        if (n_wr < 4) begin
          wr_in[n_wr] = ow_in;
          wr_sb[n_wr] = ow_start_bit;
          wr_eb[n_wr] = ow_end_bit;
        end
        n_wr++;
      end
      if (ow_read) begin
        w    = int'(ow_end_bit) - int'(ow_start_bit) + 1;
        sh   = sp >> rd_ptr;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        out_next = sh[63:0] & mask;
        rd_ptr += w;
        if (n_rd < 4) rd_eb[n_rd] = ow_end_bit;
        n_rd++;
      end
      eng_busy  <= 1'b1;
      eng_timer = 4;
    end else if (eng_timer > 0) begin
      eng_timer--;
      if (eng_timer == 0) begin
        eng_busy    <= 1'b0;
        ow_presence <= pres_cfg;
        ow_out      <= out_next;
        last_fall   = cyc;
      end
    end
  end

  function automatic logic [7:0] crc8_bits(
    input logic [71:0] d,
    input int          n
  );
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  function automatic logic [71:0] sp_basic();
    logic [63:0] b;
    b = 64'h100C_FF7F_464B_0191;
    return {crc8_bits({8'h00, b}, 64), b};
  endfunction

  task automatic clear_log();
    n_rst  = 0;
    n_wr   = 0;
    n_rd   = 0;
    n_done = 0;
    n_viol = 0;
    gap    = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    repeat (maxc) begin
      @(negedge clk);
      if (n_done > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_conv(input int maxc, output bit ok);
    ok = 1'b0;
    repeat (maxc) begin
      @(negedge clk);
      if (n_wr >= 1 && !eng_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, err_nopres, err_crc} !== 4'b0) begin
      bad++;
      $display("FAIL rst_flags: got %b want 0000",
               {busy, done, err_nopres, err_crc});
    end
    total++;
    if (temp !== 16'h0) begin
      bad++;
      $display("FAIL rst_temp: got %h want 0000", temp);
    end
    total++;
    if ({ow_reset, ow_write, ow_read} !== 3'b0) begin
      bad++;
      $display("FAIL rst_strobes: got %b want 000",
               {ow_reset, ow_write, ow_read});
    end
    total++;
    if ({ow_in, ow_start_bit, ow_end_bit} !== 76'h0) begin
      bad++;
      $display("FAIL rst_cmd: got %h/%0d/%0d want 0/0/0",
               ow_in, ow_start_bit, ow_end_bit);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    clear_log();
    sp       = sp_basic();
    pres_cfg = 1'b1;
    pulse_start();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy_hi: got %b want 1", busy);
    end
    wait_done(2000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_timeout: got no done want done");
    end
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL basic_done_busy: got %b want 00", {done, busy});
    end
    total++;
    if (temp !== 16'h0191) begin
      bad++;
      $display("FAIL basic_temp: got %h want 0191", temp);
    end
    total++;
    if ({err_nopres, err_crc} !== 2'b00) begin
      bad++;
      $display("FAIL basic_err: got %b want 00", {err_nopres, err_crc});
    end
    total++;
    if (n_rst != 2 || n_wr != 2 || n_rd != EXP_RD) begin
      bad++;
      $display("FAIL basic_counts: got %0d/%0d/%0d want 2/2/%0d",
               n_rst, n_wr, n_rd, EXP_RD);
    end
    total++;
    if (wr_in[0] !== 64'h44CC || wr_sb[0] !== 6'd0 || wr_eb[0] !== 6'd15) begin
      bad++;
      $display("FAIL basic_conv_cmd: got %h/%0d/%0d want 44cc/0/15",
               wr_in[0], wr_sb[0], wr_eb[0]);
    end
    total++;
    if (wr_in[1] !== 64'hBECC || wr_sb[1] !== 6'd0 || wr_eb[1] !== 6'd15) begin
      bad++;
      $display("FAIL basic_read_cmd: got %h/%0d/%0d want becc/0/15",
               wr_in[1], wr_sb[1], wr_eb[1]);
    end
    total++;
    if (rd_eb[0] !== EXP_EB) begin
      bad++;
      $display("FAIL basic_read_eb: got %0d want %0d", rd_eb[0], EXP_EB);
    end
    // Busy fall, one FIN edge, CONV wait edges, ISSUE edge, strobe seen.
    total++;
    if (gap != CONV + 3) begin
      bad++;
      $display("FAIL basic_gap: got %0d want %0d", gap, CONV + 3);
    end
    repeat (20) @(negedge clk);
    total++;
    if (n_done != 1 || n_viol != 0) begin
      bad++;
      $display("FAIL basic_pulse: got done=%0d viol=%0d want 1/0",
               n_done, n_viol);
    end
  endtask

  task automatic test_nopres();
    bit ok;
    clear_log();
    pres_cfg = 1'b0;
    pulse_start();
    wait_done(2000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL nopres_timeout: got no done want done");
    end
    repeat (20) @(negedge clk);
    total++;
    if (err_nopres !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL nopres_flags: got err=%b busy=%b want 1/0",
               err_nopres, busy);
    end
    total++;
    if (n_rst != 1 || n_wr != 0 || n_rd != 0 || n_done != 1) begin
      bad++;
      $display("FAIL nopres_counts: got %0d/%0d/%0d/%0d want 1/0/0/1",
               n_rst, n_wr, n_rd, n_done);
    end
    pres_cfg = 1'b1;
  endtask

  task automatic test_start_ignored();
    bit ok, ok2;
    clear_log();
    sp = sp_basic();
    pulse_start();
    wait_conv(500, ok);
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done(2000, ok2);
    repeat (300) @(negedge clk);
    total++;
    if (!(ok && ok2)) begin
      bad++;
      $display("FAIL ign_timeout: got %b%b want 11", ok, ok2);
    end
    total++;
    if (n_done != 1 || n_rst != 2 || n_wr != 2) begin
      bad++;
      $display("FAIL ign_counts: got %0d/%0d/%0d want 1/2/2",
               n_done, n_rst, n_wr);
    end
    total++;
    if (temp !== 16'h0191 || err_nopres !== 1'b0) begin
      bad++;
      $display("FAIL ign_temp: got %h/%b want 0191/0", temp, err_nopres);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2;
    clear_log();
    sp = sp_basic();
    pulse_start();
    wait_conv(500, ok);
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, ow_reset, ow_write, ow_read} !== 5'b0 ||
        temp !== 16'h0 || ow_in !== 64'h0) begin
      bad++;
      $display("FAIL mid_rst_out: got %b/%h/%h want 0/0/0",
               {busy, done, ow_reset, ow_write, ow_read}, temp, ow_in);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (300) @(negedge clk);
    total++;
    if (!ok || n_done != 0 || n_rst != 1) begin
      bad++;
      $display("FAIL mid_abandon: got ok=%b done=%0d rst=%0d want 1/0/1",
               ok, n_done, n_rst);
    end
    clear_log();
    pulse_start();
    wait_done(2000, ok2);
    total++;
    if (!ok2 || temp !== 16'h0191 || n_rst != 2 || n_wr != 2) begin
      bad++;
      $display("FAIL mid_restart: got ok=%b t=%h r=%0d w=%0d want 1/0191/2/2",
               ok2, temp, n_rst, n_wr);
    end
    total++;
    if (gap != CONV + 3 || wr_in[0] !== 64'h44CC) begin
      bad++;
      $display("FAIL mid_restart_seq: got gap=%0d w0=%h want %0d/44cc",
               gap, wr_in[0], CONV + 3);
    end
  endtask

  task automatic test_busy_hold();
    bit ok;
    clear_log();
    sp       = sp_basic();
    ext_busy = 1'b1;
    pulse_start();
    repeat (10) @(negedge clk);
    total++;
    if (n_rst != 0 || ow_reset !== 1'b0) begin
      bad++;
      $display("FAIL hold_no_strobe: got %0d/%b want 0/0", n_rst, ow_reset);
    end
    ext_busy = 1'b0;
    wait_done(2000, ok);
    total++;
    if (!ok || temp !== 16'h0191 || n_rst != 2 || n_wr != 2 ||
        n_viol != 0) begin
      bad++;
      $display("FAIL hold_complete: got ok=%b t=%h r=%0d w=%0d v=%0d want 1/0191/2/2/0",
               ok, temp, n_rst, n_wr, n_viol);
    end
  endtask

`ifdef OW_TEMP_CRC_EN
  task automatic test_crc();
    bit ok;
    clear_log();
    sp = 72'h1C_100C_FF7F_464B_0550;
    pulse_start();
    wait_done(2000, ok);
    total++;
    if (!ok || temp !== 16'h0550 || err_crc !== 1'b0) begin
      bad++;
      $display("FAIL crc_good: got ok=%b t=%h e=%b want 1/0550/0",
               ok, temp, err_crc);
    end
    clear_log();
    sp = 72'h1D_100C_FF7F_464B_0550;
    pulse_start();
    wait_done(2000, ok);
    total++;
    if (!ok || temp !== 16'h0550 || err_crc !== 1'b1) begin
      bad++;
      $display("FAIL crc_bad: got ok=%b t=%h e=%b want 1/0550/1",
               ok, temp, err_crc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_nopres();
    test_start_ignored();
    test_reset_mid();
    test_busy_hold();
`ifdef OW_TEMP_CRC_EN
    test_crc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
